// File: rtl/nabp_sinogram_arbiter.sv
// Round-robin arbiter sharing the single sinogram read port among NUM_REQ NABP lanes.
// Optional conflict counter output when NABP_SG_ARB_STATS_EN is defined.

module nabp_sg_arb_lane #(
  parameter int LW  = 2,
  parameter int IDX = 0
) (
  input  logic          gnt_any,
  input  logic [LW-1:0] gnt_idx,
  input  logic          tag_vld,
  input  logic [LW-1:0] tag_lane,
  output logic          ready,
  output logic          resp_hit
);
  assign ready    = gnt_any && (gnt_idx == LW'(IDX));
  assign resp_hit = tag_vld && (tag_lane == LW'(IDX));
endmodule

module nabp_sinogram_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 12,
  parameter int RAM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         sg_addr,
  input  logic [DATA_WIDTH-1:0]         sg_val,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_val,
  output logic                          busy
`ifdef NABP_SG_ARB_STATS_EN
  ,
  output logic [15:0]                   stat_conflicts
`endif
);
  localparam int LW     = $clog2(NUM_REQ);
  localparam int STAGES = RAM_LATENCY;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [LW-1:0]                      ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]              sg_addr_q, sg_addr_d;
  logic [STAGES:0]                    vld_pipe_q, vld_pipe_d;
  logic [STAGES:0][LW-1:0]            lane_pipe_q, lane_pipe_d;
  logic [NUM_REQ-1:0]                 resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]              resp_val_q, resp_val_d;
  logic [NUM_REQ-1:0]                 resp_hit;
  logic                               gnt_any;
  logic [LW-1:0]                      gnt_idx;
  logic [LW:0]                        cand;
  logic                               tag_out;

  assign lane_addr = req_addr;

  // Rotating search from ptr; flush masks every grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (LW+1)'(k);
      if (cand >= (LW+1)'(NUM_REQ)) cand = cand - (LW+1)'(NUM_REQ);
      if (!gnt_any && req_valid[cand[LW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[LW-1:0];
      end
    end
    if (flush) gnt_any = 1'b0;
  end

  assign tag_out = vld_pipe_q[STAGES] && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      nabp_sg_arb_lane #(.LW(LW), .IDX(gi)) u_lane (
        .gnt_any  (gnt_any),
        .gnt_idx  (gnt_idx),
        .tag_vld  (tag_out),
        .tag_lane (lane_pipe_q[STAGES]),
        .ready    (req_ready[gi]),
        .resp_hit (resp_hit[gi])
      );
    end
  endgenerate

  always_comb begin
    ptr_d = ptr_q;
    if (flush)
      ptr_d = '0;
    else if (gnt_any)
      ptr_d = (gnt_idx == LW'(NUM_REQ-1)) ? '0 : gnt_idx + LW'(1);

    sg_addr_d = gnt_any ? lane_addr[gnt_idx] : sg_addr_q;

    // Tag stage 0 lines up with sg_addr; the last stage lines up with sg_val.
    vld_pipe_d     = '0;
    lane_pipe_d    = '0;
    vld_pipe_d[0]  = gnt_any;
    lane_pipe_d[0] = gnt_idx;
    for (int s = 1; s <= STAGES; s++) begin
      vld_pipe_d[s]  = vld_pipe_q[s-1];
      lane_pipe_d[s] = lane_pipe_q[s-1];
    end
    if (flush) vld_pipe_d = '0;

    resp_valid_d = resp_hit;
    resp_val_d   = tag_out ? sg_val : resp_val_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      sg_addr_q    <= '0;
      vld_pipe_q   <= '0;
      lane_pipe_q  <= '0;
      resp_valid_q <= '0;
      resp_val_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      sg_addr_q    <= sg_addr_d;
      vld_pipe_q   <= vld_pipe_d;
      lane_pipe_q  <= lane_pipe_d;
      resp_valid_q <= resp_valid_d;
      resp_val_q   <= resp_val_d;
    end
  end

  assign sg_addr    = sg_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_val   = resp_val_q;
  assign busy       = (|req_valid) | (|vld_pipe_q);

`ifdef NABP_SG_ARB_STATS_EN
  logic [15:0] stat_q, stat_d;
  logic        multi;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign multi = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_comb begin
    stat_d = stat_q;
    if (flush)
      stat_d = '0;
    else if (multi && stat_q != 16'hFFFF)
      stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stat_q <= '0;
    else          stat_q <= stat_d;
  end

  assign stat_conflicts = stat_q;
`endif
endmodule
